// File: rtl/nn_pkg.sv
// Shared types and sizing for the neural-network image loader.
package nn_pkg;

    localparam int N_PIX = 784;
    localparam int PIX_W = 8;
    localparam int IDX_W = 10;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:N_PIX-1] img_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

endpackage

// File: rtl/pix_quant.sv
// Maps an unsigned 0..255 pixel onto the network's non-negative signed range 0..127.
module pix_quant
    import nn_pkg::*;
(
    input  logic [PIX_W-1:0] pix_in,
    output pixel_t           pix_out
);

    // Truncating halve; the result MSB is always zero so the value stays non-negative.
    assign pix_out = pixel_t'(pix_in >> 3'd1);

endmodule

// File: rtl/nn_img_loader.sv
// Streams one 28x28 frame into a parallel buffer, runs the network on it and
// captures the classified digit.
module nn_img_loader
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             pix_ready,
    output img_t             img,
    output logic             nn_enable,
    input  logic             nn_done,
    input  logic [7:0]       nn_digit,
    output logic [7:0]       digit_out,
    output logic             digit_valid,
    output logic             busy,
    output logic             frame_err
);

    ld_state_t        state_r;
    logic [IDX_W-1:0] idx_r;
    logic             pix_ready_r;
    logic             nn_enable_r;
    logic [7:0]       digit_out_r;
    logic             digit_valid_r;
    logic             busy_r;
    logic             frame_err_r;
    img_t             img_r;

    logic             accept_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             frame_end_s;
    pixel_t           quant_s;

    pix_quant u_pix_quant (
        .pix_in  (pix_data),
        .pix_out (quant_s)
    );

    assign accept_s    = pix_valid && pix_ready_r && (state_r == LOAD);
    assign wr_idx_s    = pix_sof ? {IDX_W{1'b0}} : idx_r;
    assign frame_end_s = (wr_idx_s == LAST_IDX);

    // Frame buffer: cleared on reset, otherwise overwritten in place one entry per accepted beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            img_r <= '0;
        end else if (accept_s) begin
            img_r[wr_idx_s] <= quant_s;
        end else begin
            img_r <= img_r;
        end
    end

    // LOAD -> RUN -> DONE sequencing; every handshake output is a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= LOAD;
            idx_r         <= {IDX_W{1'b0}};
            pix_ready_r   <= 1'b0;
            nn_enable_r   <= 1'b0;
            digit_out_r   <= 8'd0;
            digit_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            digit_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state_r)
                LOAD: begin
                    pix_ready_r <= 1'b1;
                    nn_enable_r <= 1'b0;
                    busy_r      <= 1'b0;
                    if (accept_s) begin
                        // A start-of-frame mid-frame restarts at entry 0 and flags it.
                        frame_err_r <= pix_sof && (idx_r != {IDX_W{1'b0}});
                        if (frame_end_s) begin
                            idx_r       <= {IDX_W{1'b0}};
                            state_r     <= RUN;
                            pix_ready_r <= 1'b0;
                            nn_enable_r <= 1'b1;
                            busy_r      <= 1'b1;
                        end else begin
                            idx_r <= wr_idx_s + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    pix_ready_r <= 1'b0;
                    busy_r      <= 1'b1;
                    if (nn_done) begin
                        digit_out_r   <= nn_digit;
                        digit_valid_r <= 1'b1;
                        nn_enable_r   <= 1'b0;
                        state_r       <= DONE;
                    end else begin
                        nn_enable_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Single settle cycle guarantees enable is low between frames.
                    state_r     <= LOAD;
                    pix_ready_r <= 1'b1;
                    nn_enable_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= LOAD;
                    idx_r       <= {IDX_W{1'b0}};
                    pix_ready_r <= 1'b0;
                    nn_enable_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign img         = img_r;
    assign pix_ready   = pix_ready_r;
    assign nn_enable   = nn_enable_r;
    assign digit_out   = digit_out_r;
    assign digit_valid = digit_valid_r;
    assign busy        = busy_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_nn_img_loader.sv
// Randomised bench for nn_img_loader against a frame-level reference model.
module tb_nn_img_loader;
    import nn_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic       pix_sof = 1'b0;
    logic       nn_done = 1'b0;
    logic [7:0] nn_digit = 8'd0;
    logic       pix_ready;
    logic       nn_enable;
    logic       digit_valid;
    logic       busy;
    logic       frame_err;
    logic [7:0] digit_out;
    img_t       img;

    int total = 0;
    int bad = 0;
    int exp_img[N_PIX];
    int m_idx = 0;
    int dv_count = 0;
    int fe_count = 0;

    nn_img_loader dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_ready   (pix_ready),
        .img         (img),
        .nn_enable   (nn_enable),
        .nn_done     (nn_done),
        .nn_digit    (nn_digit),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (digit_valid === 1'b1) dv_count++;
        if (frame_err === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int img_mismatches();
        int n = 0;
        for (int k = 0; k < N_PIX; k++)
            if (int'(img[k]) != exp_img[k]) n++;
        return n;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N_PIX; k++) exp_img[k] = 0;
        m_idx = 0;
    endfunction

    // Offer one beat (optionally after random idle cycles) and update the model on acceptance.
    task automatic send_beat(input logic [7:0] d, input logic sof, input bit gaps, output bit last);
        bit acc;
        int w;
        last = 1'b0;
        if (gaps) begin
            while ($urandom_range(0, 99) < 30) begin
                pix_valid = 1'b0;
                pix_sof   = 1'($urandom_range(0, 1));
                pix_data  = 8'($urandom);
                tick();
            end
        end
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            acc = (pix_ready === 1'b1);
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        w = sof ? 0 : m_idx;
        exp_img[w] = int'(d) / 2;
        if (w == N_PIX - 1) begin
            m_idx = 0;
            last = 1'b1;
        end else begin
            m_idx = w + 1;
        end
    endtask

    task automatic pulse_done(input logic [7:0] d);
        nn_digit = d;
        nn_done  = 1'b1;
        tick();
        nn_done  = 1'b0;
        nn_digit = 8'($urandom);
    endtask

    initial begin
        bit last;
        int n;
        logic [7:0] d;

        model_clear();

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_enable", nn_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_digit", digit_out, 0);
        check("rst_dvalid", digit_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_img", img_mismatches(), 0);
        reset = 1'b1;
        tick();
        check("rst_ready", pix_ready, 1);

        // Frame A: ramp pattern, spurious done mid-load
        for (int k = 0; k < N_PIX; k++) begin
            send_beat(8'((2 * k) % 256), k == 0, 1'b1, last);
            if (k == 0) check("sof_no_err", frame_err, 0);
            if (k == 400) begin
                pulse_done(8'd3);
                check("spur_dvalid", digit_valid, 0);
                check("spur_digit", digit_out, 0);
                check("spur_busy", busy, 0);
            end
            if (k == N_PIX - 2) check("no_en_early", nn_enable, 0);
        end
        check("a_last", last, 1);
        check("a_enable", nn_enable, 1);
        check("a_ready", pix_ready, 0);
        check("a_busy", busy, 1);
        check("a_img5", img[5], 5);
        check("a_img200", img[200], 72);
        check("a_img_all", img_mismatches(), 0);

        // Backpressure during RUN
        pix_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            pix_data = 8'($urandom);
            pix_sof  = 1'($urandom_range(0, 1));
            tick();
            if (pix_ready !== 1'b0 || nn_enable !== 1'b1) n++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check("bp_hold", n, 0);
        check("bp_img", img_mismatches(), 0);

        pulse_done(8'd7);
        check("a_digit", digit_out, 7);
        check("a_dvalid", digit_valid, 1);
        check("a_en_off", nn_enable, 0);
        check("done_ready", pix_ready, 0);
        check("done_busy", busy, 1);
        tick();
        check("a_dvalid_end", digit_valid, 0);
        check("ready_back", pix_ready, 1);
        check("idle_busy", busy, 0);

        // Frame B: resume at 0 without sof, then premature sof
        for (int k = 0; k < 100; k++) begin
            send_beat(8'($urandom), 1'b0, 1'b1, last);
            if (k == 0) check("resume_idx0", img[0], exp_img[0]);
        end
        send_beat(8'd200, 1'b1, 1'b0, last);
        check("ferr_pulse", frame_err, 1);
        check("ferr_img0", img[0], 100);
        tick();
        check("ferr_end", frame_err, 0);
        d = 8'($urandom);
        send_beat(d, 1'b0, 1'b1, last);
        check("ferr_idx1", img[1], int'(d) / 2);
        for (int k = 2; k < N_PIX; k++) begin
            if (k == N_PIX - 1) check("b_no_en_early", nn_enable, 0);
            send_beat(8'($urandom), 1'b0, 1'b1, last);
        end
        check("b_last", last, 1);
        check("b_enable", nn_enable, 1);
        check("b_img_all", img_mismatches(), 0);
        repeat ($urandom_range(1, 10)) tick();
        check("b_wait_en", nn_enable, 1);
        d = 8'($urandom_range(128, 255));
        pulse_done(d);
        check("b_digit", digit_out, d);
        repeat (2) tick();

        // Reset mid-load
        for (int k = 0; k < 300; k++) send_beat(8'($urandom), k == 0, 1'b1, last);
        reset = 1'b0;
        tick();
        model_clear();
        check("mid_rst_img", img_mismatches(), 0);
        check("mid_rst_en", nn_enable, 0);
        check("mid_rst_digit", digit_out, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_ready", pix_ready, 1);

        // Fresh frame with quantisation corner values
        for (int k = 0; k < N_PIX; k++) begin
            case (k)
                0:       d = 8'd255;
                1:       d = 8'd254;
                2:       d = 8'd1;
                3:       d = 8'd0;
                default: d = 8'($urandom);
            endcase
            send_beat(d, k == 0, 1'b1, last);
        end
        check("q_img0", img[0], 127);
        check("q_img1", img[1], 127);
        check("q_img2", img[2], 0);
        check("q_img3", img[3], 0);
        check("c_enable", nn_enable, 1);
        check("c_img_all", img_mismatches(), 0);

        // Reset during RUN
        reset = 1'b0;
        tick();
        check("run_rst_en", nn_enable, 0);
        check("run_rst_busy", busy, 0);
        reset = 1'b1;
        tick();
        check("run_rst_ready", pix_ready, 1);
        tick();

        check("dvalid_count", dv_count, 2);
        check("ferr_count", fe_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
